// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - serial frame receiver with a valid/ready output holding register.
// Optional parity stage is compiled in with UART_PARITY_EN.
module uart_frame_rx #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 baud_clk,
   input  logic                 reset,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 active_flag,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

   state_t               state;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 stop_err;
   logic                 frame_bad;
   logic                 can_load;

`ifdef UART_PARITY_EN
   logic par_bit;
   logic par_bad;
   assign par_bad = ((^shift_reg) ^ par_bit) != 1'(PARITY_ODD);
`else
   assign parity_err = 1'b0;
`endif

   // The current stop sample is folded in so the last stop bit counts toward frame_err.
   assign frame_bad = stop_err | ~rx_in;
   assign can_load  = ~data_valid | data_ready;

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         stop_err    <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         active_flag <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
         par_bit     <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         if (data_ready) data_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_in) begin
                  state       <= S_DATA;
                  bit_cnt     <= '0;
                  stop_err    <= 1'b0;
                  active_flag <= 1'b1;
               end
            end
            S_DATA: begin
               shift_reg <= {rx_in, shift_reg[DATA_BITS-1:1]};
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt <= '0;
`ifdef UART_PARITY_EN
                  state   <= S_PARITY;
`else
                  state   <= S_STOP;
`endif
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               par_bit <= rx_in;
               state   <= S_STOP;
            end
`endif
            S_STOP: begin
               if (bit_cnt == LAST_STOP) begin
                  state       <= S_IDLE;
                  bit_cnt     <= '0;
                  active_flag <= 1'b0;
                  // A held word not being consumed this edge wins; the new frame is lost.
                  if (can_load) begin
                     data_out   <= shift_reg;
                     data_valid <= 1'b1;
                     frame_err  <= frame_bad;
`ifdef UART_PARITY_EN
                     parity_err <= par_bad;
`endif
                  end else begin
                     overrun_err <= 1'b1;
                  end
               end else begin
                  stop_err <= frame_bad;
                  bit_cnt  <= bit_cnt + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed and randomized frames against a transaction-level receiver model.
module tb_uart_frame_rx;
   localparam int DB   = 8;
   localparam int SB   = 1;
   localparam int PODD = 0;
`ifdef UART_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   logic          baud_clk   = 1'b0;
   logic          reset      = 1'b1;
   logic          rx_in      = 1'b1;
   logic          data_ready = 1'b0;
   logic [DB-1:0] data_out;
   logic          data_valid, active_flag, frame_err, parity_err, overrun_err;

   int checks = 0;
   int errors = 0;

   logic          m_valid = 1'b0;
   logic          m_fe    = 1'b0;
   logic          m_pe    = 1'b0;
   logic          m_ovr   = 1'b0;
   logic [DB-1:0] m_data  = '0;

   uart_frame_rx #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
      .baud_clk   (baud_clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .active_flag(active_flag),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err)
   );

   always #5 baud_clk = ~baud_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag);
      check({tag, ".valid"},   16'(data_valid),  16'(m_valid));
      check({tag, ".data"},    16'(data_out),    16'(m_data));
      check({tag, ".ferr"},    16'(frame_err),   16'(m_fe));
      check({tag, ".perr"},    16'(parity_err),  16'(m_pe));
      check({tag, ".overrun"}, 16'(overrun_err), 16'(m_ovr));
   endtask

   // One bit time; the model applies the delivery/handshake rules for that edge.
   task automatic clk_edge(input logic rx, input logic rdy, input bit last, input logic exp_act,
                           input logic [DB-1:0] w, input logic fe, input logic pe);
      rx_in      = rx;
      data_ready = rdy;
      @(posedge baud_clk);
      #1;
      if (last && (!m_valid || rdy)) begin
         m_valid = 1'b1;
         m_data  = w;
         m_fe    = fe;
         m_pe    = pe;
      end else if (last) begin
         m_ovr = 1'b1;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      check("active", 16'(active_flag), 16'(exp_act));
   endtask

   task automatic idle_edge(input logic rdy);
      clk_edge(1'b1, rdy, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [DB-1:0] w, input logic pbad, input logic slow,
                             input logic rdy_body, input logic rdy_last);
      logic bits[$];
      logic p, fe, pe;
      int   n;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(w[i]);
      p = (^w) ^ 1'(PODD) ^ pbad;
      if (PEN != 0) bits.push_back(p);
      for (int i = 0; i < SB; i++) bits.push_back(~slow);
      fe = slow;
      pe = (PEN != 0) ? (((^w) ^ p) != 1'(PODD)) : 1'b0;
      n  = bits.size();
      for (int i = 0; i < n; i++)
         clk_edge(bits[i], (i == n - 1) ? rdy_last : rdy_body, (i == n - 1), (i != n - 1), w, fe, pe);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      rx_in      = 1'b1;
      data_ready = 1'b0;
      @(posedge baud_clk);
      #1;
      reset   = 1'b0;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_pe    = 1'b0;
      m_ovr   = 1'b0;
      m_data  = '0;
      check("reset.active", 16'(active_flag), 16'(0));
   endtask

   initial begin
      logic [DB-1:0] w;
      logic          pbad, slow, rb, rl;
      int            gap;

      @(posedge baud_clk);
      do_reset();
      check_out("reset");

      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out("a5_clean");

      send_frame(8'hA5, 1'(PEN), 1'b0, 1'b0, 1'b1);
      check_out("a5_parity");

      send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      check_out("break");
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out("after_break");

      idle_edge(1'b1);
      check_out("consumed");

      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out("overrun");
      idle_edge(1'b1);
      check_out("overrun_drain");
      idle_edge(1'b0);
      check_out("overrun_sticky");

      do_reset();
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out("replace_on_ready");

      clk_edge(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) clk_edge(1'(i & 1), 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      do_reset();
      check_out("midframe_reset");
      idle_edge(1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out("after_reset_55");

      for (int k = 0; k < 40; k++) begin
         w    = DB'($urandom);
         pbad = (PEN != 0) && ($urandom_range(0, 3) == 0);
         slow = ($urandom_range(0, 5) == 0);
         rb   = 1'($urandom_range(0, 1));
         rl   = 1'($urandom_range(0, 1));
         send_frame(w, pbad, slow, rb, rl);
         check_out("rand");
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_edge(1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits checked (legal 1 or 2).
REQ-003 SHALL have parameter PARITY_ODD, default 0, parity sense when parity is compiled in (0 = even, 1 = odd).
REQ-004 SHALL have port baud_clk  input  1  bit-rate clock; one rx_in sample per rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_in  input  1  serial line, idle high, LSB first.
REQ-007 SHALL have port data_out  output  DATA_BITS  last delivered data word.
REQ-008 SHALL have port data_valid  output  1  data_out and error flags hold an undelivered frame.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data_out this cycle.
REQ-010 SHALL have port active_flag  output  1  a frame is being received.
REQ-011 SHALL have port frame_err  output  1  delivered frame had a stop bit sampled low.
REQ-012 SHALL have port parity_err  output  1  delivered frame failed its parity check.
REQ-013 SHALL have port overrun_err  output  1  sticky: a completed frame was dropped.

Function
REQ-014 SHALL implement the states IDLE, DATA, PARITY and STOP; PARITY exists only with UART_PARITY_EN.
REQ-015 IDLE SHALL move to DATA on an edge sampling rx_in=0; that start-bit sample is consumed and not stored.
REQ-016 DATA SHALL store DATA_BITS consecutive samples LSB first, using a bit counter, then move to PARITY or STOP.
REQ-017 PARITY SHALL take one sample; parity_err SHALL be computed as XOR(data, parity bit) != PARITY_ODD.
REQ-018 STOP SHALL take STOP_BITS samples; any 0 sample SHALL mark the frame's frame_err; no early exit.
REQ-019 At the edge sampling the last stop bit, the frame SHALL be delivered and the state SHALL return to IDLE.
REQ-020 Delivery SHALL load data_out, frame_err and parity_err and set data_valid, all visible after that same edge.
REQ-021 IDLE SHALL detect a new start bit on the first edge after delivery, so back-to-back frames need no gap.
REQ-022 Errored frames SHALL still be delivered, with their error flags set.
REQ-023 A line held low (break) SHALL yield frame_err=1 and SHALL then immediately begin a new frame.
REQ-024 data_valid SHALL stay 1, and data_out and the error flags SHALL stay stable, until an edge with data_ready=1; after that edge data_valid SHALL be 0.
REQ-025 If delivery coincides with data_ready=1 on a valid word, the new word SHALL be loaded, data_valid SHALL stay 1, and no overrun SHALL occur.
REQ-026 If delivery occurs while data_valid=1 and data_ready=0, the new frame SHALL be dropped, the old word kept and overrun_err set.
REQ-027 overrun_err SHALL stay set until reset.
REQ-028 active_flag SHALL be 1 exactly while the state is DATA, PARITY or STOP.

Reset
REQ-029 On an edge with reset=1, state SHALL become IDLE, the counter 0, and data_out, data_valid, active_flag, frame_err, parity_err and overrun_err all 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no delivery; reset SHALL take priority over all other events.

Configuration
REQ-031 With macro UART_PARITY_EN defined, the PARITY state and check SHALL be included; the frame is start + DATA_BITS + parity + STOP_BITS.
REQ-032 Without UART_PARITY_EN, no parity bit SHALL be sampled, parity_err SHALL be tied to 0, and PARITY_ODD SHALL be ignored.

Verification
REQ-033 Parity on, even, DATA_BITS=8: send 0,1,0,1,0,0,1,0,1,0,1 -> data_out=0xA5, data_valid=1 after the 11th edge, errors 0.
REQ-034 Same frame with the parity bit set to 1 -> data_out=0xA5, parity_err=1, frame_err=0.
REQ-035 Stop bit 0 (rx_in held low) -> frame_err=1, active_flag=1 again on the next edge.
REQ-036 Send 0x3C then 0xC3 with data_ready=0 -> data_out=0x3C retained, overrun_err=1; after data_ready=1, data_valid=0.
REQ-037 Hold data_ready=1 on the delivery edge of a second frame -> data_out=new word, data_valid=1, overrun_err=0.
REQ-038 Assert reset after 4 data bits, then send 0x55 -> no delivery of the partial frame; 0x55 is delivered cleanly.
